// File: rtl/sprite_fetch_compositor.sv
// Fetches the background texel then one texel per sprite slot from spriteRAM and composites them
// into one palette index; fixed NUM_SPR+3 cycle latency, one pixel in flight, starts ignored while busy.
module sprite_fetch_compositor #(
  parameter int          NUM_SPR     = 4,
  parameter logic [4:0]  TRANSPARENT = 5'd0,
  parameter int          MAP_W       = 320,
  parameter logic [17:0] MAP1_BASE   = 18'd1707,
  parameter logic [17:0] MAP2_BASE   = 18'd78507
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pixel_start,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  input  logic                    map_sel,
  input  logic [NUM_SPR-1:0]      spr_en,
  input  logic [10*NUM_SPR-1:0]   spr_x,
  input  logic [10*NUM_SPR-1:0]   spr_y,
  input  logic [18*NUM_SPR-1:0]   spr_base,
  input  logic [6*NUM_SPR-1:0]    spr_w,
  input  logic [6*NUM_SPR-1:0]    spr_h,
  output logic [17:0]             ram_addr,
  input  logic [4:0]              ram_q,
  output logic                    busy,
  output logic                    pixel_valid,
  output logic [4:0]              pixel_index
);

  localparam int CW = $clog2(NUM_SPR + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t state, state_nxt;
  logic   accept, last_issue, done;

  logic [CW-1:0]           cnt;
  logic [9:0]              lx, ly;
  logic                    lmap;
  logic [NUM_SPR-1:0]      len;
  logic [10*NUM_SPR-1:0]   lsx, lsy;
  logic [18*NUM_SPR-1:0]   lbase;
  logic [6*NUM_SPR-1:0]    lw, lh;

  logic       d1_vld, d1_bg, d1_hit;
  logic       d2_vld, d2_bg, d2_hit;
  logic [4:0] acc, acc_nxt;

  logic        cur_en;
  logic [9:0]  cur_sx, cur_sy;
  logic [17:0] cur_base;
  logic [5:0]  cur_w, cur_h;

  logic        slot_bg, hit_spr, slot_hit;
  logic [10:0] x11, y11, sx11, sy11, xe11, ye11;
  logic [9:0]  dx, dy;
  logic [17:0] bg_addr, spr_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    last_issue = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (pixel_start) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == CW'(NUM_SPR)) begin
          last_issue = 1'b1;
          state_nxt  = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slot 0 is the background; sprite slot i reads descriptor i-1.
  always_comb begin
    cur_en   = 1'b0;
    cur_sx   = '0;
    cur_sy   = '0;
    cur_base = '0;
    cur_w    = '0;
    cur_h    = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (cnt == CW'(i + 1)) begin
        cur_en   = len[i];
        cur_sx   = lsx[i*10 +: 10];
        cur_sy   = lsy[i*10 +: 10];
        cur_base = lbase[i*18 +: 18];
        cur_w    = lw[i*6 +: 6];
        cur_h    = lh[i*6 +: 6];
      end
    end
  end

  // Bounds compared at 11 bits so a sprite near the right/bottom edge never wraps.
  always_comb begin
    x11      = {1'b0, lx};
    y11      = {1'b0, ly};
    sx11     = {1'b0, cur_sx};
    sy11     = {1'b0, cur_sy};
    xe11     = sx11 + {5'b0, cur_w};
    ye11     = sy11 + {5'b0, cur_h};
    slot_bg  = (cnt == '0);
    hit_spr  = cur_en && (x11 >= sx11) && (x11 < xe11) && (y11 >= sy11) && (y11 < ye11);
    slot_hit = slot_bg || hit_spr;
    dx       = lx - cur_sx;
    dy       = ly - cur_sy;
    bg_addr  = (lmap ? MAP2_BASE : MAP1_BASE) + 18'(ly[9:1]) * 18'(MAP_W) + 18'(lx[9:1]);
    spr_addr = cur_base + 18'(dy) * 18'(cur_w) + 18'(dx);
  end

  always_comb begin
    acc_nxt = acc;
    if (d2_vld) begin
      if (d2_bg)                              acc_nxt = ram_q;
      else if (d2_hit && ram_q != TRANSPARENT) acc_nxt = ram_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      lx          <= '0;
      ly          <= '0;
      lmap        <= 1'b0;
      len         <= '0;
      lsx         <= '0;
      lsy         <= '0;
      lbase       <= '0;
      lw          <= '0;
      lh          <= '0;
      ram_addr    <= '0;
      d1_vld      <= 1'b0;
      d1_bg       <= 1'b0;
      d1_hit      <= 1'b0;
      d2_vld      <= 1'b0;
      d2_bg       <= 1'b0;
      d2_hit      <= 1'b0;
      acc         <= '0;
      busy        <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_index <= '0;
    end else begin
      pixel_valid <= done;
      d2_vld      <= d1_vld;
      d2_bg       <= d1_bg;
      d2_hit      <= d1_hit;
      acc         <= acc_nxt;

      if (accept) begin
        lx    <= pixel_x;
        ly    <= pixel_y;
        lmap  <= map_sel;
        len   <= spr_en;
        lsx   <= spr_x;
        lsy   <= spr_y;
        lbase <= spr_base;
        lw    <= spr_w;
        lh    <= spr_h;
        cnt   <= '0;
        busy  <= 1'b1;
      end

      if (state == ISSUE) begin
        if (slot_hit) ram_addr <= slot_bg ? bg_addr : spr_addr;
        d1_vld <= 1'b1;
        d1_bg  <= slot_bg;
        d1_hit <= slot_hit;
        cnt    <= last_issue ? '0 : cnt + CW'(1);
      end else begin
        d1_vld <= 1'b0;
        d1_bg  <= 1'b0;
        d1_hit <= 1'b0;
      end

      if (state == DRAIN) cnt <= cnt + CW'(1);

      if (done) begin
        pixel_index <= acc_nxt;
        busy        <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sprite_fetch_compositor.md
Name: sprite_fetch_compositor

Overview:
- Upstream driver of spriteRAM: the only block that drives its 18-bit address and consumes its 5-bit palette index.
- For each requested pixel (x, y) it fetches the background map texel, then one texel per sprite layer.
- Layers composite in fixed priority with a transparent index; one 5-bit palette index is emitted to the downstream palette/VGA colour stage.
- Fixed latency, one pixel in flight, so upstream line-prefetch logic can schedule deterministically.

Parameters:
- NUM_SPR, 4, number of sprite layers (slot 0 = background, slots 1..NUM_SPR = sprites).
- TRANSPARENT, 5'd0, palette index treated as see-through for sprites.
- MAP_W, 320, background map row length in texels (map is half resolution, 320x240).
- MAP1_BASE, 18'd1707, spriteRAM base of map 1.
- MAP2_BASE, 18'd78507, spriteRAM base of map 2.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- pixel_start  in  1  request strobe, sampled only when busy=0
- pixel_x  in  10  screen x, 0..639
- pixel_y  in  10  screen y, 0..479
- map_sel  in  1  0 = map 1, 1 = map 2
- spr_en  in  NUM_SPR  per-sprite enable; bit i-1 belongs to slot i
- spr_x  in  10*NUM_SPR  sprite top-left x, packed, slot 1 in LSBs
- spr_y  in  10*NUM_SPR  sprite top-left y, packed
- spr_base  in  18*NUM_SPR  spriteRAM base address of the sprite image, packed
- spr_w  in  6*NUM_SPR  sprite width in texels, 1..63
- spr_h  in  6*NUM_SPR  sprite height in texels, 1..63
- ram_addr  out  18  registered address to spriteRAM
- ram_q  in  5  spriteRAM data; valid one clock edge after the address is sampled
- busy  out  1  high while a pixel is in flight
- pixel_valid  out  1  single-cycle strobe
- pixel_index  out  5  composited palette index, valid when pixel_valid=1

Behaviour:
- Reset (async, any time, including mid-pixel):
  - ram_addr, pixel_index, busy and pixel_valid all go to 0.
  - FSM returns to IDLE and all pipeline hit flags clear.
  - No partial pixel is ever emitted.
- FSM states: IDLE -> ISSUE (NUM_SPR+1 cycles, one slot per cycle) -> DRAIN (2 cycles) -> IDLE.
- Edge E0: pixel_start=1 in IDLE. Latch x, y, map_sel and all sprite descriptors; busy<=1.
  - Descriptor changes after E0 do not affect the pixel in flight.
  - pixel_start while busy=1 is ignored, not queued.
- Edge E(1+i), slot i: ram_addr <= address for slot i; a hit flag for slot i enters a 2-stage delay line.
  - Slot 0 address: base + (y>>1)*MAP_W + (x>>1), where base = MAP1_BASE or MAP2_BASE. Slot 0 is always a hit.
  - Slot i>=1 hit condition: spr_en=1 and sx <= x < sx+w and sy <= y < sy+h. Compare at 11 bits, so sx+w cannot overflow.
  - Slot i>=1 address on hit: spr_base + (y-sy)*w + (x-sx).
  - All address arithmetic is unsigned, modulo 2^18.
  - On a miss, ram_addr holds its previous value.
- Edge E(3+i): ram_q is sampled for slot i.
  - Slot 0 loads the accumulator unconditionally; the background is opaque, so index 0 from the map is kept.
  - Slot i>=1 overwrites the accumulator only if its hit flag is set and ram_q != TRANSPARENT.
  - Higher slot = higher priority.
- Edge E(3+NUM_SPR): pixel_index <= final accumulator, pixel_valid <= 1, busy <= 0.
  - Latency is NUM_SPR+3 cycles from start to valid, independent of hits (7 cycles at defaults).
- Next edge: pixel_valid <= 0; pixel_index holds until the next result.
  - A new pixel_start is accepted on the same edge pixel_valid deasserts; throughput is one pixel per NUM_SPR+4 cycles.
- The delay line advances every cycle in ISSUE/DRAIN; no stalls.

Test Plan:
- Reset: hold reset_n=0, then release -> ram_addr=0, pixel_index=0, busy=0, pixel_valid=0. Assert reset_n=0 at E3 of a pixel -> all outputs 0 immediately, no pixel_valid; a fresh start afterwards completes normally at E7.
- Background only: spr_en=0, map_sel=0, x=5, y=3 -> ram_addr=2029 after E1; pixel_valid exactly one cycle after E7; pixel_index=mem[2029]. Repeat with map_sel=1 -> ram_addr=78829.
- Sprite hit: slot 2, base=204, w=15, h=25, sx=100, sy=50; pixel (102,51) -> ram_addr=221 after E3; if mem[221]=7 then pixel_index=7.
- Transparency and priority: slot 1 returns 0 over bg=9 -> output 9. Slots 1 and 4 overlap, returning 3 and 12 -> output 12. Slot 4 returning 0 over slot 1 = 3 -> output 3.
- Hit boundaries, sprite at (100,50), w=15, h=25:
  - x=114, y=74 hits (offset 374).
  - x=115 misses.
  - y=49 misses.
  - sx=630, w=15, x=639 hits; no wrap.
  - A miss leaves ram_addr unchanged for that slot.
- Handshake: pulse pixel_start at E0, E2 and E6 -> only E0 is accepted; busy is high until E7. Start at E8 (after valid) is accepted; back-to-back results are 8 cycles apart.
